pc_sequencer: RTL and testbench

Fetch controller for the NanoQuarter core. It computes `new_PC` for the program counter register every cycle and runs the req/ack handshake with instruction memory. It also arbitrates redirects (trap, jump, branch) against hazard stalls and delivers fetched instructions to decode through a registered fetch stage with a one-entry skid buffer.

---
 rtl/pc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch controller. Produces the next PC every cycle, runs the
//            req/ack handshake with instruction memory, arbitrates redirects
//            (trap > jump > branch) against hazard stalls, and delivers
//            fetched words to decode through a registered stage with a
//            one-entry skid buffer.
// Ports    : clk, rst (async, active-low)
//            pc_cur / new_PC            - PC register value in / next PC out
//            stall, trap, jump, branch  - hazard hold and redirect requests
//            imem_req/addr/ack/rdata    - instruction memory handshake
//            fetch_valid/pc/instr       - registered fetch stage to decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] new_PC,
  input  logic        stall,
  input  logic        trap,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_SQUASH = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_redir_pc;
  logic        r_fetch_valid;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_fetch_instr;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_seq;
  logic [1:0]  w_state_nxt;
  logic [31:0] w_new_pc;
  logic        w_req;
  logic        w_fetch_load;
  logic        w_fetch_bubble;
  logic        w_fetch_kill;
  logic [31:0] w_fetch_pc_d;
  logic [31:0] w_fetch_instr_d;
  logic        w_skid_load;
  logic        w_redir_load;

  assign w_redirect = trap | jump | branch_taken;
  assign w_target   = trap ? TRAP_VECTOR : (jump ? jump_target : branch_target);
  assign w_pc_seq   = pc_cur + 32'd4;   // natural 32-bit wrap

  // Redirects invalidate whatever decode holds; BOOT ignores redirects.
  assign w_fetch_kill = w_redirect && (r_state != S_BOOT);

  always_comb begin
    w_state_nxt     = r_state;
    w_new_pc        = pc_cur;
    w_req           = 1'b0;
    w_fetch_load    = 1'b0;
    w_fetch_bubble  = 1'b0;
    w_fetch_pc_d    = pc_cur;
    w_fetch_instr_d = imem_rdata;
    w_skid_load     = 1'b0;
    w_redir_load    = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_new_pc    = RESET_VECTOR;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          if (w_redirect) begin
            w_new_pc = w_target;              // returned word is dropped
          end else begin
            w_new_pc = w_pc_seq;
            if (stall) begin
              w_skid_load = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_fetch_load = 1'b1;
            end
          end
        end else if (w_redirect) begin
          // Request is in flight at pc_cur; park the target until it returns.
          w_redir_load = 1'b1;
          w_state_nxt  = S_SQUASH;
        end else if (!stall) begin
          w_fetch_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_new_pc    = w_target;             // skid contents abandoned
          w_state_nxt = S_FETCH;
        end else if (!stall) begin
          w_fetch_load    = 1'b1;
          w_fetch_pc_d    = r_skid_pc;
          w_fetch_instr_d = r_skid_instr;
          w_state_nxt     = S_FETCH;
        end
      end
      S_SQUASH: begin
        w_req          = 1'b1;
        w_fetch_bubble = !stall;
        if (imem_ack) begin
          w_new_pc    = w_redirect ? w_target : r_redir_pc;
          w_state_nxt = S_FETCH;
        end else if (w_redirect) begin
          w_redir_load = 1'b1;                // latest redirect wins
        end
      end
      default: begin
        w_new_pc    = RESET_VECTOR;
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_BOOT;
      r_skid_pc     <= 32'd0;
      r_skid_instr  <= 32'd0;
      r_redir_pc    <= 32'd0;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= 32'd0;
      r_fetch_instr <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_skid_load) begin
        r_skid_pc    <= pc_cur;
        r_skid_instr <= imem_rdata;
      end
      if (w_redir_load) begin
        r_redir_pc <= w_target;
      end
      if (w_fetch_kill) begin
        r_fetch_valid <= 1'b0;
      end else if (w_fetch_load) begin
        r_fetch_valid <= 1'b1;
        r_fetch_pc    <= w_fetch_pc_d;
        r_fetch_instr <= w_fetch_instr_d;
      end else if (w_fetch_bubble) begin
        r_fetch_valid <= 1'b0;
      end
    end
  end

  // State resets asynchronously, so these drop/redirect the moment rst asserts.
  assign new_PC      = w_new_pc;
  assign imem_req    = w_req;
  assign imem_addr   = pc_cur;
  assign fetch_valid = r_fetch_valid;
  assign fetch_pc    = r_fetch_pc;
  assign fetch_instr = r_fetch_instr;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer. Acts as the PC register,
//            drives directed and random fetch/redirect/stall traffic, and
//            checks outputs against a behavioural fetch model through
//            scoreboard queues drained by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0040;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur = 32'd0;
  logic [31:0] new_PC;
  logic        stall = 1'b0, trap = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic [31:0] jump_target = 32'd0, branch_target = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        fetch_valid;
  logic [31:0] fetch_pc, fetch_instr;

  pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .new_PC(new_PC),
    .stall(stall), .trap(trap), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc_cur <= new_PC;   // the PC register

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [31:0] npc; logic req; logic [31:0] addr; } comb_t;
  typedef struct packed { logic v; logic [31:0] pc; logic [31:0] instr; } fet_t;
  comb_t q_comb[$];
  fet_t  q_fet[$];

  // Behavioural fetch model: what the core has, not how the RTL encodes it.
  logic        m_boot, m_skid_v, m_pend;
  logic [31:0] m_pc, m_skid_pc, m_skid_instr, m_pend_pc;
  logic        m_fv;
  logic [31:0] m_fpc, m_finstr;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_skid_v = 1'b0; m_pend = 1'b0;
    m_pc = RV; m_skid_pc = 32'd0; m_skid_instr = 32'd0; m_pend_pc = 32'd0;
    m_fv = 1'b0; m_fpc = 32'd0; m_finstr = 32'd0;
  endtask

  task automatic model_step(input logic st, input logic tr, input logic jp, input logic [31:0] jt,
                            input logic br, input logic [31:0] bt, input logic ack,
                            input logic [31:0] rd, output logic [31:0] npc, output logic req);
    logic        red;
    logic [31:0] tgt;
    red = tr | jp | br;
    tgt = tr ? TV : (jp ? jt : bt);
    npc = m_pc;
    req = 1'b1;
    if (m_boot) begin
      req = 1'b0; npc = RV; m_boot = 1'b0;
    end else if (m_skid_v) begin
      req = 1'b0;
      if (red) begin
        npc = tgt; m_skid_v = 1'b0; m_fv = 1'b0;
      end else if (!st) begin
        m_fv = 1'b1; m_fpc = m_skid_pc; m_finstr = m_skid_instr; m_skid_v = 1'b0;
      end
    end else if (m_pend) begin
      if (ack) begin
        npc = red ? tgt : m_pend_pc; m_pend = 1'b0;
      end else if (red) begin
        m_pend_pc = tgt;
      end
      if (red || !st) m_fv = 1'b0;
    end else begin
      if (ack && red) begin
        npc = tgt; m_fv = 1'b0;
      end else if (ack) begin
        npc = m_pc + 32'd4;
        if (st) begin
          m_skid_v = 1'b1; m_skid_pc = m_pc; m_skid_instr = rd;
        end else begin
          m_fv = 1'b1; m_fpc = m_pc; m_finstr = rd;
        end
      end else if (red) begin
        m_pend = 1'b1; m_pend_pc = tgt; m_fv = 1'b0;
      end else if (!st) begin
        m_fv = 1'b0;
      end
    end
    m_pc = npc;
  endtask

  // Apply one cycle of inputs now (called at posedge+2) and queue expectations.
  task automatic drive_now(input logic st, input logic tr, input logic jp, input logic [31:0] jt,
                           input logic br, input logic [31:0] bt, input logic ackw);
    logic        req_now, req;
    logic [31:0] npc, old_pc;
    comb_t       c;
    fet_t        f;
    req_now = !m_boot && !m_skid_v;
    stall = st; trap = tr; jump = jp; jump_target = jt;
    branch_taken = br; branch_target = bt;
    imem_ack = ackw & req_now;
    imem_rdata = $urandom;
    #1;
    old_pc = m_pc;
    model_step(st, tr, jp, jt, br, bt, imem_ack, imem_rdata, npc, req);
    c.npc = npc; c.req = req; c.addr = old_pc;
    q_comb.push_back(c);
    f.v = m_fv; f.pc = m_fpc; f.instr = m_finstr;
    q_fet.push_back(f);
  endtask

  task automatic cycle(input logic st, input logic tr, input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic ackw);
    @(posedge clk);
    #2;
    drive_now(st, tr, jp, jt, br, bt, ackw);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    stall = 1'b0; trap = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    #1;
    chk32("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk32("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk32("rst_new_PC", new_PC, RV);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    drive_now(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Combinational-output monitor, mid-cycle.
  always @(negedge clk) begin
    comb_t e;
    if (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      chk32("new_PC", new_PC, e.npc);
      chk32("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      if (e.req) chk32("imem_addr", imem_addr, e.addr);
    end
  end

  // Fetch-stage monitor, just after the edge that loads it.
  always @(posedge clk) begin
    fet_t e;
    #1;
    if (q_fet.size() > 0) begin
      e = q_fet.pop_front();
      chk32("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.v});
      if (e.v) begin
        chk32("fetch_pc", fetch_pc, e.pc);
        chk32("fetch_instr", fetch_instr, e.instr);
      end
    end
  end

  initial begin
    model_reset();
    do_reset();                                               // BOOT cycle
    // Sequential fetch with stall at 0x44
    cycle(0, 0, 0, 0, 0, 0, 1);                               // ack @0x40
    chk32("first_addr", imem_addr, RV);
    cycle(1, 0, 0, 0, 0, 0, 1);                               // ack @0x44, stall
    chk32("addr_44", imem_addr, 32'h44);
    cycle(1, 0, 0, 0, 0, 0, 1);                               // HOLD
    chk32("hold_req", {31'd0, imem_req}, 32'd0);
    chk32("hold_fetch_pc", fetch_pc, 32'h40);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);                               // stall drops
    cycle(0, 0, 0, 0, 0, 0, 1);                               // resumes
    chk32("resume_fetch_pc", fetch_pc, 32'h44);
    chk32("resume_addr", imem_addr, 32'h48);
    // jump + branch, no ack -> SQUASH; late ack
    cycle(0, 0, 1, 32'h200, 1, 32'h300, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk32("squash_ack_new_PC", new_PC, 32'h200);
    cycle(0, 0, 1, 32'h200, 1, 32'h300, 0);
    chk32("after_squash_addr", imem_addr, 32'h200);
    cycle(0, 1, 0, 0, 0, 0, 0);                               // trap while squashing
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk32("trap_new_PC", new_PC, TV);
    // wrap boundary
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk32("wrap_new_PC", new_PC, 32'd0);
    // reset while a squashed request is outstanding
    cycle(0, 0, 1, 32'h600, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk32("post_rst_addr", imem_addr, RV);
    chk32("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic st, tr, jp, br, ak;
      logic [31:0] jt, bt;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        st = ($urandom_range(0, 99) < 30);
        tr = ($urandom_range(0, 99) < 4);
        jp = ($urandom_range(0, 99) < 8);
        br = ($urandom_range(0, 99) < 8);
        ak = ($urandom_range(0, 99) < 60);
        jt = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        bt = $urandom & 32'hFFFF_FFFC;
        cycle(st, tr, jp, jt, br, bt, ak);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    if (q_comb.size() != 0 || q_fet.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d comb / %0d fetch expectations left, required 0", q_comb.size(), q_fet.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
